// File: rtl/mem_port_arbiter.sv
// Arbiter that shares one memory port between instruction fetch and data access.
// Define MEM_ARB_PERF_EN to add stall and conflict performance counters.
module mem_port_arbiter #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [DATA_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_rd,
    input  logic              dm_wr,
    input  logic [DATA_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              err
`ifdef MEM_ARB_PERF_EN
    ,
    input  logic              perf_clr,
    output logic [31:0]       perf_stall_cyc,
    output logic [31:0]       perf_conflict_cyc
`endif
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);
    localparam logic [DATA_W-1:0] DEAD = DATA_W'(32'hDEADBEEF);

    typedef enum logic [1:0] {
        IDLE,
        IF_BUSY,
        DM_BUSY
    } state_e;

    state_e            state_q, state_d;
    logic              if_done_q, if_done_d;
    logic              dm_done_q, dm_done_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] ifr_q, ifr_d;
    logic [DATA_W-1:0] dmr_q, dmr_d;
    logic              err_q, err_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     cnt_inc;
    logic              fin;
    logic [DATA_W-1:0] fin_val;
    logic              if_need;
    logic              dm_need;

    assign if_need = if_req & ~if_done_q;
    assign dm_need = (dm_rd | dm_wr) & ~dm_done_q;
    assign stall   = if_need | dm_need;
    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        if_done_d = if_done_q;
        dm_done_d = dm_done_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        ifr_d     = ifr_q;
        dmr_d     = dmr_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        fin       = 1'b0;
        fin_val   = mem_rdata;

        if (!stall) begin
            if_done_d = 1'b0;
            dm_done_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (dm_need) begin
                    state_d = DM_BUSY;
                    req_d   = 1'b1;
                    we_d    = dm_wr;
                    addr_d  = dm_addr;
                    wdata_d = dm_wdata;
                    cnt_d   = '0;
                end else if (if_need) begin
                    state_d = IF_BUSY;
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    addr_d  = if_addr;
                    cnt_d   = '0;
                end
            end
            IF_BUSY, DM_BUSY: begin
                if (mem_ack) begin
                    fin = 1'b1;
                end else if (cnt_inc == TMAX) begin
                    fin     = 1'b1;
                    fin_val = DEAD;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase

        // Completion (ack or timeout) always returns ownership to IDLE
        if (fin) begin
            state_d = IDLE;
            req_d   = 1'b0;
            we_d    = 1'b0;
            if (state_q == IF_BUSY) begin
                ifr_d     = fin_val;
                if_done_d = 1'b1;
            end else begin
                dmr_d     = fin_val;
                dm_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            if_done_q <= 1'b0;
            dm_done_q <= 1'b0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            ifr_q     <= '0;
            dmr_q     <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            if_done_q <= if_done_d;
            dm_done_q <= dm_done_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            ifr_q     <= ifr_d;
            dmr_q     <= dmr_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_rdata  = ifr_q;
    assign dm_rdata  = dmr_q;
    assign err       = err_q;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] pstall_q;
    logic [31:0] pconf_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pstall_q <= '0;
            pconf_q  <= '0;
        end else if (perf_clr) begin
            pstall_q <= '0;
            pconf_q  <= '0;
        end else begin
            if (stall && !(&pstall_q)) begin
                pstall_q <= pstall_q + 32'd1;
            end
            if (if_need && dm_need && !(&pconf_q)) begin
                pconf_q <= pconf_q + 32'd1;
            end
        end
    end

    assign perf_stall_cyc    = pstall_q;
    assign perf_conflict_cyc = pconf_q;
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the pipeline's instruction fetch (IF) and data access (MEM stage) requesters.
- Sequences one memory transaction at a time over a req/ack handshake.
- Drives a single global pipeline stall that holds while either requester still needs service.
- Sits between the IF/MEM stages and the memory. It replaces the two independent memories.

Parameters:
- DATA_W, 32, data and address width
- TIMEOUT, 15, max BUSY cycles waiting for mem_ack before aborting (4-bit counter width suffices for default; width = clog2(TIMEOUT+1))

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-low reset
- if_req  input  1  fetch request (level)
- if_addr  input  DATA_W  fetch address
- if_rdata  output  DATA_W  registered fetched instruction
- dm_rd  input  1  data read request (level)
- dm_wr  input  1  data write request (level)
- dm_addr  input  DATA_W  data address
- dm_wdata  input  DATA_W  write data
- dm_rdata  output  DATA_W  registered read data
- stall  output  1  global pipeline stall; pipeline advances on edges where stall=0
- mem_req  output  1  memory request, held until mem_ack or timeout
- mem_we  output  1  memory write enable
- mem_addr  output  DATA_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  memory read data, valid with mem_ack
- mem_ack  input  1  one-cycle transaction completion
- err  output  1  sticky timeout flag

Behaviour:
- Reset (rst=0, async): state IDLE; if_done=dm_done=0; mem_req=mem_we=0; mem_addr, mem_wdata, if_rdata, dm_rdata=0; err=0; timeout counter=0.
- Needs:
  - if_need = if_req & ~if_done
  - dm_need = (dm_rd|dm_wr) & ~dm_done
- stall = if_need | dm_need (combinational).
- On an edge with stall=0, both done flags clear.
- FSM:
  - IDLE:
    - if dm_need -> DM_BUSY; latch mem_addr=dm_addr, mem_we=dm_wr, mem_wdata=dm_wdata.
    - else if if_need -> IF_BUSY; latch mem_addr=if_addr, mem_we=0.
    - Data has fixed priority.
  - IF_BUSY / DM_BUSY:
    - mem_req=1 (registered); inputs are not re-sampled.
    - On mem_ack: capture mem_rdata into the owner's rdata register, set the owner's done flag, drop mem_req/mem_we, -> IDLE.
- Latency: request first seen in IDLE at cycle 0; mem_req high from cycle 1. With mem_ack in cycle 1, done sets at end of cycle 1 and stall=0 in cycle 2.
- Both requesting at cycle 0 with 1-cycle ack: DM served cycles 1, IDLE 2, IF 3, stall low cycle 4.
- dm_wr: dm_rdata is still updated with mem_rdata (memory defined value); dm_rd=dm_wr=1 is illegal, treated as write.
- Requesters hold req/addr/wdata stable while stall=1.
- Timeout:
  - Counter increments each BUSY cycle without mem_ack, and clears on entering BUSY.
  - If it reaches TIMEOUT: drop mem_req, set err (sticky), load owner rdata with 32'hDEADBEEF, set owner done, -> IDLE.
  - A late mem_ack arriving in IDLE is ignored.
- mem_ack in IDLE: ignored.
- Reset mid-transaction: the transaction is abandoned; the memory must tolerate mem_req dropping without ack.

Optional Feature:
- Macro MEM_ARB_PERF_EN.
- Defined:
  - Adds outputs perf_stall_cyc (32) and perf_conflict_cyc (32), plus input perf_clr (1, synchronous).
  - perf_stall_cyc counts cycles with stall=1.
  - perf_conflict_cyc counts cycles with if_need&dm_need.
  - Both counters saturate at all-ones and reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Fetch only:
  - Stimulus: if_req=1, if_addr=0x10; memory acks the cycle after mem_req with 0x8C010004.
  - Response: stall high 2 cycles; mem_we=0; if_rdata=0x8C010004 when stall falls.
- Conflict:
  - Stimulus: if_req and dm_rd (addr 0x100) together; 1-cycle ack.
  - Response: DM transaction first with mem_addr=0x100, then IF; stall low in cycle 4; both rdata correct.
- Write:
  - Stimulus: dm_wr=1, dm_addr=0x20, dm_wdata=0xCAFEF00D.
  - Response: one transaction with mem_we=1 and those values; single write only, even with if_req held across the access.
- Timeout:
  - Stimulus: never ack.
  - Response: mem_req drops after 15 BUSY cycles; err=1 sticky; dm_rdata=0xDEADBEEF; stall falls.
- Reset mid-BUSY:
  - Stimulus: rst=0 while mem_req=1.
  - Response: outputs return to reset values immediately; state IDLE; after release, the pending request is re-arbitrated cleanly.
- Perf (MEM_ARB_PERF_EN):
  - Stimulus: conflict scenario.
  - Response: perf_stall_cyc=4, perf_conflict_cyc=2; perf_clr zeroes both.
